// File: rtl/instr_queue.sv
// Fetch-to-decode instruction FIFO: zero-latency head view, one cycle enqueue-to-visible.
// Fetch ready depends only on registered fullness and clear; decode stalls never reach fetch combinationally.
package maverickOne_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
endpackage

module instr_queue #(
  parameter int XLEN  = maverickOne_pkg::XLEN,
  parameter int ILEN  = maverickOne_pkg::ILEN,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     clear_i,
  input  logic                     fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [ILEN-1:0]          fetch_code_i,
  input  logic [XLEN-1:0]          fetch_pc_i,
  output logic                     decode_valid_o,
  input  logic                     decode_ready_i,
  output logic [ILEN-1:0]          decode_code_o,
  output logic [XLEN-1:0]          decode_pc_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ILEN-1:0] code_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  assign empty_o        = (count == '0);
  assign full_o         = (count == CW'(DEPTH));
  assign count_o        = count;
  assign fetch_ready_o  = ~full_o & ~clear_i;
  assign decode_valid_o = ~empty_o & ~clear_i;
  assign push           = fetch_valid_i & fetch_ready_o;
  assign pop            = decode_valid_o & decode_ready_i;

  // Data is gated while empty so stale storage never leaks to decode.
  assign decode_code_o = empty_o ? '0 : code_mem[rd_ptr];
  assign decode_pc_o   = empty_o ? '0 : pc_mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (srst_i || clear_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (push && !srst_i) begin
      code_mem[wr_ptr] <= fetch_code_i;
      pc_mem[wr_ptr]   <= fetch_pc_i;
    end
  end

  a_count_max: assert property (@(posedge clk_i) count <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (srst_i) !(push && full_o));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (srst_i) !(pop && empty_o));
  a_head_stable: assert property (@(posedge clk_i) disable iff (srst_i)
    (decode_valid_o && !decode_ready_i) |=> ($stable(decode_pc_o) && $stable(decode_code_o)));

endmodule

// File: tb/tb_instr_queue.sv
// Randomized and directed bench for instr_queue with a queue-based reference model and scoreboard monitor.
module tb_instr_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        clear = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_code = '0;
  logic [31:0] fetch_pc = '0;
  logic        decode_valid;
  logic        decode_ready = 1'b0;
  logic [31:0] decode_code;
  logic [31:0] decode_pc;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  instr_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .srst_i(srst), .clear_i(clear),
    .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready),
    .fetch_code_i(fetch_code), .fetch_pc_i(fetch_pc),
    .decode_valid_o(decode_valid), .decode_ready_i(decode_ready),
    .decode_code_o(decode_code), .decode_pc_o(decode_pc),
    .count_o(count), .empty_o(empty), .full_o(full)
  );

  always #5 clk = ~clk;

  // Reference contents in order: {pc, code}; index 0 is the head.
  logic [63:0] exp_q[$];
  logic        pend = 1'b0;
  logic [63:0] pend_item = '0;
  logic        chk_en = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare all outputs against the model, then retire/flush for the coming edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int  sz;
      logic ev, er;
      sz = exp_q.size();
      ev = (sz > 0) && !clear;
      er = (sz < DEPTH) && !clear;
      check("count", 64'(count), 64'(sz));
      check("empty", 64'(empty), 64'(sz == 0));
      check("full", 64'(full), 64'(sz == DEPTH));
      check("fetch_ready", 64'(fetch_ready), 64'(er));
      check("decode_valid", 64'(decode_valid), 64'(ev));
      if (sz > 0 && ev) check("head", {decode_pc, decode_code}, exp_q[0]);
      else if (sz == 0) check("gated_data", {decode_pc, decode_code}, 64'd0);
      if (srst || clear) exp_q.delete();
      else if (ev && decode_ready) void'(exp_q.pop_front());
    end
  end

  task automatic cycle(input logic rst, input logic clr, input logic fv,
                       input logic [31:0] pc, input logic [31:0] code, input logic dr);
    @(posedge clk);
    #1;
    if (pend) exp_q.push_back(pend_item);
    srst = rst; clear = clr; fetch_valid = fv;
    fetch_pc = pc; fetch_code = code; decode_ready = dr;
    // A beat is accepted only if the queue is below DEPTH before this cycle's pop.
    pend = fv && !clr && !rst && (exp_q.size() < DEPTH);
    pend_item = {pc, code};
  endtask

  function automatic logic [31:0] code_of(input logic [31:0] pc);
    return pc ^ 32'hA5C3_0013;
  endfunction

  task automatic push_pc(input logic [31:0] pc, input logic dr);
    cycle(1'b0, 1'b0, 1'b1, pc, code_of(pc), dr);
  endtask

  task automatic idle(input int n, input logic dr);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, dr);
  endtask

  initial begin
    logic [31:0] pc;
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk_en = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(2, 1'b0);

    // Fill to full, attempt an extra push, then drain in order.
    for (int i = 0; i < 4; i++) push_pc(32'h1000 + 32'(4 * i), 1'b0);
    push_pc(32'h1010, 1'b0);
    idle(6, 1'b1);

    // Wrap-around at occupancy 3.
    for (int i = 0; i < 3; i++) push_pc(32'h4000 + 32'(4 * i), 1'b0);
    for (int i = 3; i < 9; i++) push_pc(32'h4000 + 32'(4 * i), 1'b1);
    idle(5, 1'b1);

    // Push/pop at count 2, then pop while full.
    push_pc(32'h5000, 1'b0);
    push_pc(32'h5004, 1'b0);
    push_pc(32'h5008, 1'b1);
    push_pc(32'h500C, 1'b0);
    push_pc(32'h5010, 1'b0);
    push_pc(32'h5014, 1'b1);
    push_pc(32'h5018, 1'b0);
    idle(6, 1'b1);

    // Flush with a beat presented during clear.
    for (int i = 0; i < 3; i++) push_pc(32'h6000 + 32'(4 * i), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h2000, code_of(32'h2000), 1'b0);
    push_pc(32'h3000, 1'b0);
    idle(3, 1'b1);

    // Multi-cycle clear, then reset mid-stream with everything asserted.
    for (int i = 0; i < 3; i++) push_pc(32'h7000 + 32'(4 * i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 32'h7100, 32'h1, 1'b1);
    for (int i = 0; i < 3; i++) push_pc(32'h8000 + 32'(4 * i), 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h9000, code_of(32'h9000), 1'b1);
    idle(3, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      pc = $urandom;
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) < 6), pc, $urandom, ($urandom_range(0, 9) < 5));
    end
    idle(8, 1'b1);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
